// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA controller and CPU/DMA bus multiplexer for the NES.
// Optional 2A03 odd-cycle read alignment: define OAM_DMA_ODD_ALIGN_EN.
module nes_oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic [15:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DATA,
  input  logic        i_CPU_R_WN,
  input  logic [7:0]  i_BUS_DATA,
  output logic        o_CPU_PAUSE,
  output logic [15:0] o_BUS_ADDR,
  output logic [7:0]  o_BUS_DATA,
  output logic        o_BUS_R_WN
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_pause;
  logic        w_trig;

  assign w_trig      = (i_CPU_ADDR == TRIGGER_ADDR) && !i_CPU_R_WN;
  assign o_CPU_PAUSE = r_pause;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic r_cyc_odd;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) r_cyc_odd <= 1'b0;
    else          r_cyc_odd <= ~r_cyc_odd;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    o_BUS_ADDR  = i_CPU_ADDR;
    o_BUS_DATA  = i_CPU_DATA;
    o_BUS_R_WN  = i_CPU_R_WN;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        o_BUS_ADDR = {r_page, 8'h00};
        o_BUS_DATA = '0;
        o_BUS_R_WN = 1'b1;
`ifdef OAM_DMA_ODD_ALIGN_EN
        // An even HALT cycle would put READ on an odd cycle; pad by one.
        w_state_nxt = r_cyc_odd ? ST_READ : ST_ALIGN;
`else
        w_state_nxt = ST_READ;
`endif
      end
      ST_ALIGN: begin
        o_BUS_ADDR  = {r_page, 8'h00};
        o_BUS_DATA  = '0;
        o_BUS_R_WN  = 1'b1;
        w_state_nxt = ST_READ;
      end
      ST_READ: begin
        o_BUS_ADDR  = {r_page, r_idx};
        o_BUS_DATA  = '0;
        o_BUS_R_WN  = 1'b1;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        o_BUS_ADDR  = OAMDATA_ADDR;
        o_BUS_DATA  = r_data;
        o_BUS_R_WN  = 1'b0;
        w_state_nxt = (r_idx == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state <= ST_IDLE;
      r_pause <= 1'b0;
      r_page  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Pause is a registered decode of the state being entered.
      r_pause <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_page <= i_CPU_DATA;
            r_idx  <= '0;
          end
        end
        ST_READ:  r_data <= i_BUS_DATA;
        ST_WRITE: r_idx  <= r_idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: memory model on the bus, scoreboard of
// expected OAMDATA writes, pause length and read-address sequence checks.
module tb_nes_oam_dma;

  logic        i_CLK;
  logic        i_RST_N;
  logic [15:0] i_CPU_ADDR;
  logic [7:0]  i_CPU_DATA;
  logic        i_CPU_R_WN;
  logic [7:0]  i_BUS_DATA;
  logic        o_CPU_PAUSE;
  logic [15:0] o_BUS_ADDR;
  logic [7:0]  o_BUS_DATA;
  logic        o_BUS_R_WN;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q [$];
  int          n_pass;
  int          n_chk;
  logic [31:0] m_cyc;

  nes_oam_dma #(.TRIGGER_ADDR(16'h4014), .OAMDATA_ADDR(16'h2004)) dut (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .i_CPU_ADDR (i_CPU_ADDR),
    .i_CPU_DATA (i_CPU_DATA),
    .i_CPU_R_WN (i_CPU_R_WN),
    .i_BUS_DATA (i_BUS_DATA),
    .o_CPU_PAUSE(o_CPU_PAUSE),
    .o_BUS_ADDR (o_BUS_ADDR),
    .o_BUS_DATA (o_BUS_DATA),
    .o_BUS_R_WN (o_BUS_R_WN)
  );

  assign i_BUS_DATA = mem[o_BUS_ADDR];

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Independent cycle-parity model (counts clocks since reset release).
  always @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) m_cyc <= 0;
    else          m_cyc <= m_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic rwn);
    i_CPU_ADDR = a;
    i_CPU_DATA = d;
    i_CPU_R_WN = rwn;
  endtask

  task automatic check_pass(input string tag, input logic [15:0] a, input logic [7:0] d,
                            input logic rwn);
    chk({tag, "_addr"}, {16'h0, o_BUS_ADDR}, {16'h0, a});
    chk({tag, "_rwn"}, {31'h0, o_BUS_R_WN}, {31'h0, rwn});
    if (!rwn) chk({tag, "_data"}, {24'h0, o_BUS_DATA}, {24'h0, d});
    chk({tag, "_pause"}, {31'h0, o_CPU_PAUSE}, 32'h0);
  endtask

  // Trigger a DMA from page and follow it to completion, or reset it when the
  // READ of abort_idx is on the bus (abort_idx < 256).
  task automatic dma_run(input logic [7:0] page, input int abort_idx);
    int          plen, writes, first_wr, exp_len, exp_first;
    bit          done, odd_t;
    logic [15:0] prev_addr, last_rd;
    logic        prev_rwn;
    logic [7:0]  ed;
    logic [15:0] a;
    @(negedge i_CLK);
    cpu_drive(16'h4014, page, 1'b0);
    #1;
    odd_t = m_cyc[0];
    check_pass("trig", 16'h4014, page, 1'b0);
    for (int i = 0; i < 256; i++) begin
      a = {page, 8'(i)};
      exp_q.push_back(mem[a]);
    end
`ifdef OAM_DMA_ODD_ALIGN_EN
    exp_len   = odd_t ? 514 : 513;
    exp_first = odd_t ? 4 : 3;
`else
    exp_len   = 513;
    exp_first = 3;
`endif
    plen = 0; writes = 0; first_wr = 0; done = 0;
    prev_addr = o_BUS_ADDR; prev_rwn = o_BUS_R_WN; last_rd = '0;
    for (int c = 1; c <= 700 && !done; c++) begin
      @(negedge i_CLK);
      cpu_drive(16'h8000, 8'h00, 1'b1);
      #1;
      if (!o_CPU_PAUSE) begin
        done = 1;
        check_pass("end_idle", 16'h8000, 8'h00, 1'b1);
      end else begin
        plen++;
        if (abort_idx < 256 && o_BUS_R_WN && writes == abort_idx &&
            o_BUS_ADDR == {page, 8'(abort_idx)}) begin
          #1 i_RST_N = 1'b0;
          #1;
          check_pass("rst_async", 16'h8000, 8'h00, 1'b1);
          exp_q.delete();
          @(negedge i_CLK);
          chk("rst_hold_pause", {31'h0, o_CPU_PAUSE}, 32'h0);
          i_RST_N = 1'b1;
          return;
        end
        if (!o_BUS_R_WN) begin
          chk("wr_addr", {16'h0, o_BUS_ADDR}, 32'h2004);
          chk("rd_before_wr", {31'h0, prev_rwn}, 32'h1);
          chk("rd_addr", {16'h0, prev_addr}, {16'h0, page, 8'(writes)});
          last_rd = prev_addr;
          if (exp_q.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
          else begin
            ed = exp_q.pop_front();
            chk("wr_data", {24'h0, o_BUS_DATA}, {24'h0, ed});
          end
          if (writes == 0) first_wr = c;
          writes++;
        end
      end
      prev_addr = o_BUS_ADDR;
      prev_rwn  = o_BUS_R_WN;
    end
    if (!done) chk("timeout", 32'h1, 32'h0);
    chk("pause_len", plen, exp_len);
    chk("n_writes", writes, 256);
    chk("first_wr_cyc", first_wr, exp_first);
    chk("last_rd", {16'h0, last_rd}, {16'h0, page, 8'hFF});
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] a;
    n_pass = 0;
    n_chk  = 0;
    for (int i = 0; i < 65536; i++) begin
      a = 16'(i);
      mem[i] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'hA5) : (a[7:0] + a[15:8] * 8'd7);
    end
    cpu_drive(16'h8000, 8'h00, 1'b1);
    i_RST_N = 1'b0;
    #12;
    chk("reset_pause", {31'h0, o_CPU_PAUSE}, 32'h0);
    chk("reset_pass", {16'h0, o_BUS_ADDR}, 32'h8000);
    @(negedge i_CLK);
    i_RST_N = 1'b1;

    // Passthrough read and write
    @(negedge i_CLK); cpu_drive(16'h8000, 8'h12, 1'b1); #1;
    check_pass("pt_rd", 16'h8000, 8'h12, 1'b1);
    @(negedge i_CLK); cpu_drive(16'h0300, 8'h55, 1'b0); #1;
    check_pass("pt_wr", 16'h0300, 8'h55, 1'b0);

    // Non-trigger accesses
    @(negedge i_CLK); cpu_drive(16'h4014, 8'h02, 1'b1); #1;
    check_pass("nt_rd4014", 16'h4014, 8'h02, 1'b1);
    @(negedge i_CLK); cpu_drive(16'h4015, 8'h02, 1'b0); #1;
    check_pass("nt_wr4015", 16'h4015, 8'h02, 1'b0);
    @(negedge i_CLK); cpu_drive(16'h8001, 8'h00, 1'b1); #1;
    check_pass("nt_after", 16'h8001, 8'h00, 1'b1);
    @(negedge i_CLK); #1;
    chk("nt_after2_pause", {31'h0, o_CPU_PAUSE}, 32'h0);

    // Basic copy from page $02, then page $07 one cycle later (other parity)
    dma_run(8'h02, 256);
    dma_run(8'h07, 256);
    @(negedge i_CLK); cpu_drive(16'h8000, 8'h00, 1'b1);
    dma_run(8'h07, 256);

    // Reset during READ of index $40, then a fresh copy from page $03
    dma_run(8'h05, 8'h40);
    @(negedge i_CLK); cpu_drive(16'h8002, 8'h00, 1'b1); #1;
    check_pass("post_rst", 16'h8002, 8'h00, 1'b1);
    dma_run(8'h03, 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
